// File: rtl/arb_sched_pkg.sv
// arb_sched_pkg: shared sizes, FSM states and one-hot helper for the round-robin scheduler
package arb_sched_pkg;
    localparam int N_REQ = 16;
    localparam int IDX_W = 4;
    typedef enum logic {IDLE, GRANT} state_t;
    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction
endpackage

// File: rtl/rr_pick_16.sv
// rr_pick_16: circular first-set search of req starting at ptr
module rr_pick_16
    import arb_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_valid
);
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] enc;
    assign rot = N_REQ'({req, req} >> ptr);
    always_comb begin
        enc = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rot[i]) enc = IDX_W'(i);
    end
    assign pick_idx   = enc + ptr;
    assign pick_valid = |req;
endmodule

// File: rtl/rr_grant_scheduler_16.sv
// rr_grant_scheduler_16: 16-way round-robin grant with bounded hold time and
// registered one-hot / encoded grant outputs
module rr_grant_scheduler_16
    import arb_sched_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    state_t         state;
    logic [IDX_W-1:0] ptr;
    logic [HW-1:0]  hold_cnt;
    logic [IDX_W-1:0] pick_idx;
    logic           pick_valid;
    logic           owner_req;
    logic           stay;
    rr_pick_16 u_pick (
        .req       (req),
        .ptr       (ptr),
        .pick_idx  (pick_idx),
        .pick_valid(pick_valid)
    );
    assign owner_req = req[gnt_idx];
    assign stay      = enable && owner_req && hold_cnt != HOLD_LAST;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: if (enable && pick_valid) begin
                    gnt       <= onehot(pick_idx);
                    gnt_idx   <= pick_idx;
                    gnt_valid <= 1'b1;
                    hold_cnt  <= '0;
                    state     <= GRANT;
                end
                GRANT: if (stay) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end else begin
                    // only the hold limit can fail while enable and owner request are both high
                    timeout   <= enable && owner_req;
                    ptr       <= gnt_idx + 1'b1;
                    gnt       <= '0;
                    gnt_idx   <= '0;
                    gnt_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_grant_scheduler_16.sv
// tb_rr_grant_scheduler_16: randomized and directed stimulus checked by a
// scoreboard against a tenure-level reference model
module tb_rr_grant_scheduler_16;
    localparam int MAX_HOLD = 8;
    typedef struct packed {
        logic [15:0] gnt;
        logic [3:0]  idx;
        logic        valid;
        logic        to;
    } exp_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        enable = 0;
    logic [15:0] req = '0;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;

    exp_t scb[$];
    int   n_assert = 0;
    int   n_fail = 0;

    int m_owner = -1;
    int m_tenure = 0;
    int m_ptr = 0;
    bit m_to = 0;

    rr_grant_scheduler_16 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    // tenure-level model: an owner keeps the resource for at most MAX_HOLD visible cycles
    function automatic void model_step(input bit r, input bit en, input logic [15:0] q);
        if (!r) begin
            m_owner = -1; m_ptr = 0; m_tenure = 0; m_to = 0;
            return;
        end
        m_to = 0;
        if (m_owner < 0) begin
            if (en)
                for (int k = 0; k < 16; k++)
                    if (q[(m_ptr + k) % 16]) begin
                        m_owner = (m_ptr + k) % 16;
                        m_tenure = 1;
                        break;
                    end
        end else if (en && q[m_owner] && m_tenure < MAX_HOLD) begin
            m_tenure++;
        end else begin
            m_to = en && q[m_owner];
            m_ptr = (m_owner + 1) % 16;
            m_owner = -1;
        end
    endfunction

    task automatic cycle(input bit r, input bit en, input logic [15:0] q);
        exp_t e;
        rst_n = r; enable = en; req = q;
        @(posedge clk);
        model_step(r, en, q);
        e.valid = m_owner >= 0;
        e.gnt   = e.valid ? 16'(1) << m_owner : 16'h0;
        e.idx   = e.valid ? 4'(m_owner) : 4'h0;
        e.to    = m_to;
        scb.push_back(e);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_assert++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (scb.size() > 0) begin
                e = scb.pop_front();
                chk("gnt", 32'(gnt), 32'(e.gnt));
                chk("gnt_idx", 32'(gnt_idx), 32'(e.idx));
                chk("gnt_valid", 32'(gnt_valid), 32'(e.valid));
                chk("timeout", 32'(timeout), 32'(e.to));
                chk("onehot_inv", 32'(gnt), gnt_valid ? 32'(16'(1) << gnt_idx) : 32'h0);
            end
        end
    end

    initial begin : stim
        logic [15:0] q;
        repeat (2) cycle(0, 1, 16'hFFFF);
        // owner 5 interrupted by reset, then ptr must be back at 0
        repeat (3) cycle(1, 1, 16'h0020);
        cycle(0, 1, 16'h0020);
        repeat (3) cycle(1, 1, 16'h0001);
        cycle(1, 1, 16'h0000);
        repeat (2) cycle(0, 1, 16'h0000);
        // idle then a single late requester
        repeat (10) cycle(1, 1, 16'h0000);
        repeat (4) cycle(1, 1, 16'h0200);
        repeat (2) cycle(1, 1, 16'h0000);
        // rotation through timeouts
        repeat (2) cycle(0, 1, 16'h0000);
        repeat (45) cycle(1, 1, 16'h8421);
        // voluntary release after three cycles of grant
        repeat (2) cycle(1, 1, 16'h0000);
        repeat (4) cycle(1, 1, 16'h0010);
        repeat (2) cycle(1, 1, 16'h0000);
        // wrap-around through owner 14 and 15
        repeat (3) cycle(1, 1, 16'h4000);
        repeat (2) cycle(1, 1, 16'h0000);
        repeat (3) cycle(1, 1, 16'h8001);
        cycle(1, 1, 16'h0001);
        repeat (4) cycle(1, 1, 16'h8001);
        repeat (2) cycle(1, 1, 16'h0000);
        // enable drop exactly at the hold limit
        repeat (8) cycle(1, 1, 16'h0008);
        repeat (5) cycle(1, 0, 16'hFFFF);
        repeat (2) cycle(1, 1, 16'h0000);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(3))
                0: q = 16'(1) << $urandom_range(15);
                1: q = 16'($urandom) & 16'($urandom);
                2: q = 16'($urandom);
                default: q = ($urandom_range(9) == 0) ? 16'h0 : 16'hFFFF;
            endcase
            cycle($urandom_range(99) != 0, $urandom_range(15) != 0, q);
        end
        cycle(1, 1, 16'h0000);
        @(negedge clk);
        #1;
        if (scb.size() != 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", scb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_grant_scheduler_16.md
Name: rr_grant_scheduler_16

Overview:
16-requester round-robin scheduler that shares one downstream resource and drives its select lines.
- Produces a one-hot grant and a 4-bit encoded grant index for the resource mux.
- Grant is held while the owner keeps requesting, bounded by a hold timeout.
- Priority rotates past the last owner so no requester starves.

Parameters:
- N_REQ, 16, number of requesters; fixed at 16 in this revision.
- IDX_W, 4, width of encoded grant index, log2(N_REQ).
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant; legal range 2..256.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
- enable  input  1  scheduler enable; low blocks new grants and revokes the current one.
- req  input  16  per-requester request, level-sensitive; bit i = requester i.
- gnt  output  16  registered one-hot grant; all-zero when no owner.
- gnt_idx  output  4  registered binary index of the owner; 0 when gnt_valid=0.
- gnt_valid  output  1  registered; high while a grant is held.
- timeout  output  1  registered single-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset: when rst_n=0 at a clk edge:
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - Internal ptr=0, hold_cnt=0, state=IDLE.
  - Reset mid-grant drops the grant on that edge.
- State IDLE:
  - If enable=1 and |req:
    - Pick the first set req bit searching circularly from ptr upward (ptr, ptr+1, ..., 15, 0, ..., ptr-1).
    - Next edge: gnt=onehot(pick), gnt_idx=pick, gnt_valid=1, hold_cnt=0, go to GRANT.
  - Latency: req sampled in cycle n, grant visible after edge n+1.
  - Otherwise stay in IDLE with outputs zero.
- State GRANT (owner = gnt_idx):
  - Stay while enable=1, req[owner]=1 and hold_cnt < MAX_HOLD-1; hold_cnt increments each cycle.
  - Release when any stay condition fails. Next edge: gnt=0, gnt_valid=0, gnt_idx=0, ptr=(owner+1) mod 16, go to IDLE.
  - Timeout: release caused only by hold_cnt = MAX_HOLD-1 while req[owner]=1 and enable=1 → timeout=1 for exactly that one cycle.
  - Owner grant duration is therefore at most MAX_HOLD cycles.
- Dead cycle: every release is followed by at least one cycle with gnt_valid=0, so a new owner appears no earlier than 2 edges after release is decided.
- Priority pointer:
  - Advances only on release, to owner+1.
  - Wrap-around: owner 15 → ptr=0.
  - A timed-out owner that still requests is ranked last in the next search.
- Simultaneous events:
  - Release and new requests on the same cycle: release takes priority; arbitration happens in the following IDLE cycle using the updated ptr.
  - enable falling in the same cycle the hold limit is reached: release without timeout pulse (enable revoke wins).
- req bits of non-owners are ignored during GRANT.
- Invariants: gnt always zero or one-hot; gnt == (gnt_valid ? 1<<gnt_idx : 0).
- hold_cnt width is clog2(MAX_HOLD); it must not wrap.

Decomposition:
- Package arb_sched_pkg:
  - N_REQ and IDX_W localparams.
  - state enum {IDLE, GRANT}.
  - Function onehot(idx) returning the 16-bit vector.
- One combinational sub-module rr_pick_16:
  - Inputs: req[15:0], ptr[3:0].
  - Outputs: pick_idx[3:0], pick_valid.
  - Implementation: rotate req right by ptr, fixed lowest-index priority encode, add ptr mod 16.
- The top holds the FSM, pointer, hold counter and output registers.

Test Plan:
- Reset mid-grant: owner 5 granted, rst_n=0 for one edge → gnt=0, gnt_valid=0, gnt_idx=0; then req=16'h0001 → gnt_idx=0 (ptr back to 0).
- Basic rotation: req=16'h8421 held constant, MAX_HOLD=8, all owners hold to timeout → grant order 0,5,10,15,0; each tenure 8 cycles; one timeout pulse per tenure; one idle cycle between tenures.
- Voluntary release: req=16'h0010 for 3 cycles after grant, then 0 → gnt=16'h0010 for 3 cycles, no timeout pulse, ptr=5.
- Wrap-around: ptr=15 via owner 14 releasing; req=16'h8001 → gnt_idx=15; after release req=16'h8001 → gnt_idx=0.
- Enable revoke: owner 3 granted, enable=0 at hold_cnt=MAX_HOLD-1 → release next edge, timeout=0; no new grant while enable=0 even with req=16'hFFFF.
- Latency/idle: req=0 for 10 cycles → gnt_valid=0 throughout; req=16'h0200 at cycle n → gnt_idx=9, gnt_valid=1 after edge n+1, never earlier.
